// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Brief    : Read-side drain stage for an async FIFO. Pops words, absorbs the
//            1-cycle read latency in a 2-entry skid buffer and emits a
//            valid/ready stream with packet framing.
// Revision : 1.0  initial release
// ============================================================================
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 4
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [15:0]           pkt_cnt,
  output logic                  busy
);

  localparam int                  C_BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(PKT_LEN - 1);
  localparam logic [C_BEAT_W-1:0] C_BEAT_ONE  = C_BEAT_W'(1);

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [C_BEAT_W-1:0]   r_beat;
  logic [15:0]           r_pkt_cnt;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;

  logic                  w_pop;
  logic [2:0]            w_occ_nxt;
  logic [1:0]            w_wr_idx;
  logic [DATA_WIDTH-1:0] w_buf0_nxt;
  logic [DATA_WIDTH-1:0] w_buf1_nxt;

  assign w_pop = m_valid & m_ready;

  // A pop implies r_occ >= 1, so this never underflows.
  assign w_occ_nxt = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Only request when the word landing next cycle is guaranteed a free slot.
  assign fifo_r_en = ~rrst & ~fifo_empty & (w_occ_nxt < 3'd2);

  // Tail slot for an arriving word, measured after the head has been consumed.
  assign w_wr_idx = r_occ - {1'b0, w_pop};

  always_comb begin
    w_buf0_nxt = r_buf0;
    w_buf1_nxt = r_buf1;
    if (w_pop) begin
      w_buf0_nxt = r_buf1;
    end
    if (r_inflight) begin
      if (w_wr_idx == 2'd0) begin
        w_buf0_nxt = fifo_data;
      end else begin
        w_buf1_nxt = fifo_data;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_beat     <= '0;
      r_pkt_cnt  <= 16'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_occ      <= w_occ_nxt[1:0];
      r_inflight <= fifo_r_en;
      r_buf0     <= w_buf0_nxt;
      r_buf1     <= w_buf1_nxt;
      if (w_pop) begin
        r_beat <= (r_beat == C_LAST_BEAT) ? '0 : r_beat + C_BEAT_ONE;
        if (m_last) begin
          r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
      end
    end
  end

  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_buf0;
  assign m_last  = (r_beat == C_LAST_BEAT) & m_valid;
  assign pkt_cnt = r_pkt_cnt;
  assign busy    = (r_occ != 2'd0) | r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// Testbench for fifo_rd_stream: directed vector table, corner-case sequences
// and randomized traffic against a queue-based stream model.
module tb_fifo_rd_stream;
  localparam int DW = 32;
  localparam int PL = 4;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_r_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [15:0]   pkt_cnt;
  logic          busy;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .rclk(rclk), .rrst(rrst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(fifo_r_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .pkt_cnt(pkt_cnt), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // FIFO contents and the reference stream of words handed to the stage
  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  int            m_out;      // words popped from FIFO but not yet accepted downstream
  bit            m_last_ren; // word on fifo_data this cycle
  int            m_acc;      // words accepted downstream since reset
  bit            m_known;

  // Values captured at the sample point of the last step
  logic          s_ren, s_valid, s_last, s_busy, s_pop;
  logic [DW-1:0] s_data;
  logic [15:0]   s_pkt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst_v, input bit rdy);
    bit            e_valid, e_pop, e_ren, ren_now;
    logic [DW-1:0] w;
    rrst       = rst_v;
    m_ready    = rdy;
    fifo_empty = (fq.size() == 0);
    #1;
    s_ren = fifo_r_en; s_valid = m_valid; s_last = m_last; s_busy = busy;
    s_data = m_data; s_pkt = pkt_cnt; s_pop = m_valid & rdy;
    e_pop = 1'b0;
    e_ren = 1'b0;
    if (m_known) begin
      e_valid = (m_out - int'(m_last_ren)) != 0;
      e_pop   = e_valid && rdy;
      e_ren   = !rst_v && (fq.size() != 0) && (m_out - int'(e_pop) < 2);
      chk("m_valid", m_valid, e_valid);
      chk("fifo_r_en", fifo_r_en, e_ren);
      chk("busy", busy, m_out != 0);
      chk("pkt_cnt", pkt_cnt, (m_acc / PL) % 65536);
      chk("occupancy", m_out <= 2, 1);
      if (e_valid) begin
        chk("m_data", m_data, (sb.size() != 0) ? sb[0] : 32'hxxxx_xxxx);
        chk("m_last", m_last, (m_acc % PL) == PL - 1);
      end else begin
        chk("m_last_idle", m_last, 0);
      end
    end else if (rst_v) begin
      chk("fifo_r_en_rst", fifo_r_en, 0);
    end
    ren_now = fifo_r_en;
    @(posedge rclk);
    #1;
    w = 32'hDEAD_BEEF;
    if (ren_now && fq.size() != 0) begin
      w = fq.pop_front();
    end
    if (ren_now) fifo_data = w;
    if (rst_v) begin
      m_out = 0; m_last_ren = 0; m_acc = 0; sb.delete(); m_known = 1;
    end else if (m_known) begin
      if (e_pop) begin
        void'(sb.pop_front());
        m_acc++;
      end
      if (e_ren) sb.push_back(w);
      m_out      = m_out + int'(e_ren) - int'(e_pop);
      m_last_ren = e_ren;
    end
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          push;
    logic [31:0] pw;
    bit          e_ren;
    bit          e_valid;
    bit          chk_data;
    logic [31:0] e_data;
    bit          e_last;
    bit          e_busy;
    logic [15:0] e_pkt;
  } vec_t;

  vec_t vt[7];

  initial begin
    int            run, best, rens, pops;
    logic [DW-1:0] got[$];
    logic [DW-1:0] lasts[$];

    // Reset held with a non-empty FIFO, then a single-word transfer
    vt[0] = '{1, 1, 1, 32'd1, 0, 0, 1, 32'd0, 0, 0, 16'd0};
    vt[1] = '{1, 1, 0, 32'd0, 0, 0, 1, 32'd0, 0, 0, 16'd0};
    vt[2] = '{1, 1, 0, 32'd0, 0, 0, 1, 32'd0, 0, 0, 16'd0};
    vt[3] = '{0, 1, 0, 32'd0, 1, 0, 1, 32'd0, 0, 0, 16'd0};
    vt[4] = '{0, 1, 0, 32'd0, 0, 0, 0, 32'd0, 0, 1, 16'd0};
    vt[5] = '{0, 1, 0, 32'd0, 0, 1, 1, 32'd1, 0, 1, 16'd0};
    vt[6] = '{0, 1, 0, 32'd0, 0, 0, 0, 32'd0, 0, 0, 16'd0};

    m_known = 0;
    step(1, 0);
    for (int i = 0; i < 7; i++) begin
      if (vt[i].push) fq.push_back(vt[i].pw);
      step(vt[i].rst, vt[i].rdy);
      chk($sformatf("vec%0d ren", i), s_ren, vt[i].e_ren);
      chk($sformatf("vec%0d valid", i), s_valid, vt[i].e_valid);
      chk($sformatf("vec%0d last", i), s_last, vt[i].e_last);
      chk($sformatf("vec%0d busy", i), s_busy, vt[i].e_busy);
      chk($sformatf("vec%0d pkt", i), s_pkt, vt[i].e_pkt);
      if (vt[i].chk_data) chk($sformatf("vec%0d data", i), s_data, vt[i].e_data);
    end

    // Streaming 2**i with continuous ready
    step(1, 1);
    for (int i = 0; i < 8; i++) fq.push_back(32'd1 << i);
    run = 0; best = 0; rens = 0; pops = 0; got.delete(); lasts.delete();
    for (int c = 0; c < 12; c++) begin
      step(0, 1);
      if (s_ren) begin run++; if (run > best) best = run; end else run = 0;
      if (s_pop) begin
        pops++; got.push_back(s_data);
        if (s_last) lasts.push_back(s_data);
      end
    end
    chk("stream pops", pops, 8);
    chk("stream ren run", best, 8);
    chk("stream last count", lasts.size(), 2);
    if (lasts.size() == 2) begin
      chk("stream last0", lasts[0], 32'd8);
      chk("stream last1", lasts[1], 32'd128);
    end
    chk("stream pkt_cnt", s_pkt, 16'd2);
    for (int i = 0; i < got.size(); i++) chk("stream order", got[i], 32'd1 << i);

    // Backpressure then release
    step(1, 0);
    for (int i = 1; i <= 8; i++) fq.push_back(DW'(i));
    rens = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, 0);
      if (s_ren) rens++;
      if (c >= 3) begin
        chk("bp valid", s_valid, 1);
        chk("bp data stable", s_data, 32'd1);
      end
    end
    chk("bp pops", rens, 2);
    chk("bp ren low", s_ren, 0);
    run = 0; got.delete();
    for (int c = 0; c < 10; c++) begin
      step(0, 1);
      if (s_pop) got.push_back(s_data);
      if (c < 8 && s_valid) run++;
    end
    chk("bp drain no gaps", run, 8);
    chk("bp drain count", got.size(), 8);
    for (int i = 0; i < got.size(); i++) chk("bp order", got[i], DW'(i + 1));

    // Reset mid-operation after 5 words, then 4 fresh words
    step(1, 1);
    for (int i = 1; i <= 8; i++) fq.push_back(DW'(i));
    pops = 0;
    for (int c = 0; c < 20 && pops < 5; c++) begin
      step(0, 1);
      if (s_pop) pops++;
    end
    chk("midrst reached 5", pops, 5);
    step(1, 1);
    chk("midrst ren", s_ren, 0);
    fq.delete();
    fq.push_back(32'd10); fq.push_back(32'd20); fq.push_back(32'd30); fq.push_back(32'd40);
    got.delete(); lasts.delete();
    for (int c = 0; c < 10; c++) begin
      step(0, 1);
      if (s_pop) begin
        got.push_back(s_data);
        if (s_last) lasts.push_back(s_data);
      end
    end
    chk("midrst count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk("midrst data", got[i], 32'd10 * (i + 1));
    chk("midrst last count", lasts.size(), 1);
    if (lasts.size() == 1) chk("midrst last word", lasts[0], 32'd40);
    chk("midrst pkt_cnt", s_pkt, 16'd1);

    // Randomized traffic with occasional reset
    step(1, 0);
    fq.delete();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) fq.push_back($urandom);
      if ($urandom_range(0, 3) == 0) fq.push_back($urandom);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 400 && (fq.size() != 0 || m_out != 0); c++) step(0, 1);
    chk("final fifo drained", fq.size(), 0);
    chk("final stream drained", sb.size(), 0);
    step(0, 1);
    chk("final busy", s_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
